laser_lane_receiver: RTL and testbench



---
 rtl/laser_pkg.sv | 24 ++
 rtl/laser_lane_receiver_if.sv | 24 ++
 rtl/laser_sync.sv | 26 ++
 rtl/laser_lane_receiver.sv | 190 +++++++++++++++++++
 tb/tb_laser_lane_receiver.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/laser_pkg.sv
// Shared laser-link definitions: line levels, default frame geometry and receiver states.
package laser_pkg;

    localparam int unsigned LASER_OVERSAMPLE = 8;
    localparam int unsigned LASER_DATA_BITS  = 8;
    localparam int unsigned FRAME_CNT_W      = 16;

    localparam logic LINE_IDLE   = 1'b0;
    localparam logic START_LEVEL = 1'b1;
    localparam logic STOP_LEVEL  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/laser_lane_receiver_if.sv
// Receiver-side bundle of one laser lane: enable and photodiode in, recovered byte and status out.
interface laser_lane_receiver_if #(
    parameter int unsigned DATA_BITS = laser_pkg::LASER_DATA_BITS
) ();

    logic                               en;
    logic                               laser_in;
    logic [DATA_BITS-1:0]               data_out;
    logic                               data_valid;
    logic                               frame_err;
    logic                               busy;
    logic [laser_pkg::FRAME_CNT_W-1:0]  frame_count;

    modport master (
        output en, laser_in,
        input  data_out, data_valid, frame_err, busy, frame_count
    );

    modport slave (
        input  en, laser_in,
        output data_out, data_valid, frame_err, busy, frame_count
    );

endinterface

// File: rtl/laser_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
module laser_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/laser_lane_receiver.sv
// Oversampling single-lane laser deserializer with framing check and good-frame counter.
// Optional build macro LASER_RX_MAJORITY_EN: 2-of-3 vote around each bit centre (+1 cycle latency).
module laser_lane_receiver
    import laser_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = LASER_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = LASER_DATA_BITS
) (
    input  logic                  clock,
    input  logic                  reset_n,
    laser_lane_receiver_if.slave  rx
);

    localparam int unsigned PH_W = $clog2(OVERSAMPLE + 2);
    localparam int unsigned BC_W = $clog2(DATA_BITS + 1);
`ifdef LASER_RX_MAJORITY_EN
    localparam int unsigned START_PT = OVERSAMPLE / 2 + 1;
`else
    localparam int unsigned START_PT = OVERSAMPLE / 2;
`endif

    rx_state_t              state_q, state_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   busy_q;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

    logic sync_q;
    logic sync_prev_q;
    logic rise_c;
    logic sample_c;

    laser_sync #(.WIDTH(1)) u_sync (
        .clk   (clock),
        .rst_n (reset_n),
        .d_i   (rx.laser_in),
        .q_o   (sync_q)
    );

`ifdef LASER_RX_MAJORITY_EN
    logic sync_prev2_q;

    // History taps so the vote at centre+1 sees centre-1, centre and centre+1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_prev_q  <= 1'b0;
            sync_prev2_q <= 1'b0;
        end else begin
            sync_prev_q  <= sync_q;
            sync_prev2_q <= sync_prev_q;
        end
    end

    assign sample_c = maj3(sync_prev2_q, sync_prev_q, sync_q);
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_prev_q <= 1'b0;
        end else begin
            sync_prev_q <= sync_q;
        end
    end

    assign sample_c = sync_q;
`endif

    // A start needs a fresh idle-to-start edge; a line already high at enable is ignored.
    assign rise_c = rx.en && (sync_q == START_LEVEL) && (sync_prev_q == LINE_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
            fcnt_q    <= fcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        fcnt_d    = fcnt_q;

        unique case (state_q)
            IDLE: begin
                phase_d = '0;
                if (rise_c) begin
                    state_d = START;
                    phase_d = PH_W'(1);
                end
            end
            START: begin
                if (phase_q == PH_W'(START_PT)) begin
                    phase_d   = PH_W'(1);
                    bit_cnt_d = '0;
                    state_d   = (sample_c == START_LEVEL) ? DATA : IDLE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            DATA: begin
                if (phase_q == PH_W'(OVERSAMPLE)) begin
                    phase_d = PH_W'(1);
                    shift_d = {sample_c, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            STOP: begin
                if (phase_q == PH_W'(OVERSAMPLE)) begin
                    phase_d = '0;
                    if (sample_c == STOP_LEVEL) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        fcnt_d  = fcnt_q + FRAME_CNT_W'(1);
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RECOVER;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            RECOVER: begin
                // phase_q counts consecutive idle cycles here.
                if (sync_q == LINE_IDLE) begin
                    if (phase_q == PH_W'(OVERSAMPLE - 1)) begin
                        phase_d = '0;
                        state_d = IDLE;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end else begin
                    phase_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase

        if (!rx.en) begin
            state_d = IDLE;
            phase_d = '0;
            shift_d = shift_q;
            data_d  = data_q;
            valid_d = 1'b0;
            err_d   = 1'b0;
            fcnt_d  = fcnt_q;
        end
    end

    assign rx.data_out    = data_q;
    assign rx.data_valid  = valid_q;
    assign rx.frame_err   = err_q;
    assign rx.busy        = busy_q;
    assign rx.frame_count = fcnt_q;

endmodule

// File: tb/tb_laser_lane_receiver.sv
// Scoreboard bench for laser_lane_receiver: directed frames, expected pulses queued and checked by a monitor.
module tb_laser_lane_receiver;

    localparam int unsigned OS = 8;
    localparam int unsigned DB = 8;
`ifdef LASER_RX_MAJORITY_EN
    localparam int unsigned LAT = OS / 2 + OS * (DB + 1) + 2;
`else
    localparam int unsigned LAT = OS / 2 + OS * (DB + 1) + 1;
`endif

    typedef struct packed {
        logic        err;
        logic [7:0]  data;
        logic [31:0] cyc;
        logic [15:0] fcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    logic [7:0]  exp_data;
    logic [15:0] exp_fcnt;

    laser_lane_receiver_if #(.DATA_BITS(DB)) bus ();

    laser_lane_receiver #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .rx      (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.data_valid || bus.frame_err) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: valid=%b err=%b at cycle %0d, expected no pulse",
                         bus.data_valid, bus.frame_err, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", 32'({bus.frame_err, bus.data_valid}), e.err ? 32'd2 : 32'd1);
                check("data_out", 32'(bus.data_out), 32'(e.data));
                check("pulse_cycle", cyc, e.cyc);
                check("frame_count", 32'(bus.frame_count), 32'(e.fcnt));
            end
        end
    end

    task automatic drive(input logic lvl, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            bus.laser_in = lvl;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic lvl, input logic glitch);
        for (int unsigned i = 0; i < OS; i++) begin
            bus.laser_in = (glitch && i == OS / 2) ? ~lvl : lvl;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int gbit);
        int unsigned c0;
        exp_t        e;
        c0 = cyc;
        if (stop_lvl == 1'b0) begin
            exp_fcnt = exp_fcnt + 16'd1;
            exp_data = d;
            e = '{err: 1'b0, data: d, cyc: 32'(c0 + 2 + LAT), fcnt: exp_fcnt};
        end else begin
            e = '{err: 1'b1, data: exp_data, cyc: 32'(c0 + 2 + LAT), fcnt: exp_fcnt};
        end
        exp_q.push_back(e);
        drive_bit(1'b1, 1'b0);
        for (int k = 0; k < int'(DB); k++) drive_bit(d[k], k == gbit);
        drive_bit(stop_lvl, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
        check({tag, "_data_valid"}, 32'(bus.data_valid), 32'd0);
        check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_frame_count"}, 32'(bus.frame_count), 32'd0);
    endtask

    task automatic drain(input string tag);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.laser_in = 1'b0;
        exp_data     = 8'h00;
        exp_fcnt     = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        bus.en = 1'b1;
        drive(1'b0, 5);

        // Single good frame, then the receiver must be idle.
        send_frame(8'hC8, 1'b0, -1);
        drain("c8");
        check("c8_busy_after", 32'(bus.busy), 32'd0);
        drive(1'b0, 4);

        // Back-to-back frames with no idle gap.
        send_frame(8'h12, 1'b0, -1);
        send_frame(8'h34, 1'b0, -1);
        drain("b2b");
        drive(1'b0, 4);

        // Bad stop bit, recovery after OS idle cycles, then a normal frame.
        send_frame(8'h77, 1'b1, -1);
        drive(1'b0, OS);
        @(posedge clk);
        #1;
        check("recover_busy_s87", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        check("recover_busy_s88", 32'(bus.busy), 32'd0);
        check("err_data_kept", 32'(bus.data_out), 32'h34);
        send_frame(8'hA5, 1'b0, -1);
        drain("a5");
        drive(1'b0, 4);

        // Two-cycle glitch: START entered, false start returns to IDLE silently.
        drive(1'b1, 2);
        bus.laser_in = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_busy_start", 32'(bus.busy), 32'd1);
        drive(1'b0, 6);
        check("glitch_busy_idle", 32'(bus.busy), 32'd0);
        drive(1'b0, 10);
        check("glitch_frame_count", 32'(bus.frame_count), 32'(exp_fcnt));

        // Enable dropped in the middle of data bit 4.
        v = 8'h5A;
        drive_bit(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) drive_bit(v[k], 1'b0);
        drive(v[4], OS / 2);
        check("en_drop_busy_before", 32'(bus.busy), 32'd1);
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        check("en_drop_busy_after", 32'(bus.busy), 32'd0);
        drive(1'b0, 20);
        bus.en = 1'b1;
        drive(1'b0, 5);
        check("en_drop_data_kept", 32'(bus.data_out), 32'hA5);

`ifdef LASER_RX_MAJORITY_EN
        // One-cycle inversion at the centre of bit 3 is voted out.
        send_frame(8'hF0, 1'b0, 3);
        drain("maj");
        drive(1'b0, 4);
`endif

        // Asynchronous reset in the middle of a frame.
        v = 8'h3C;
        drive_bit(1'b1, 1'b0);
        for (int k = 0; k < 2; k++) drive_bit(v[k], 1'b0);
        check("midreset_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        bus.laser_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        exp_fcnt = 16'd0;
        exp_data = 8'h00;
        drive(1'b0, 5);
        send_frame(8'h81, 1'b0, -1);
        drain("post_reset");

        drive(1'b0, 10);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
